// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared constants and state encoding for the
// nibble-serial adder controller.
package nibble_serial_add_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int nibs);
    return (nibs > 1) ? $clog2(nibs) : 1;
  endfunction

endpackage

// File: rtl/full_adder_4bit_bh.sv
// Behavioural 4-bit adder with carry in/out.
// One nibble of the serial datapath per cycle.
module full_adder_4bit_bh
  import nibble_serial_add_ctrl_pkg::*;
(
  output logic [NIB_W-1:0] s,
  output logic             cout,
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin
);

  // Sum and carry of one nibble
  assign {cout, s} = {1'b0, a}
                   + {1'b0, b}
                   + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder: accepts a+b+cin, adds one
// nibble per cycle, holds the result until taken.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIBS  = WIDTH / NIB_W;
  localparam int IDX_W = idx_width(NIBS);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NIBS - 1);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               cout_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NIB_W-1:0]   nib_a;
  logic [NIB_W-1:0]   nib_b;
  logic [NIB_W-1:0]   nib_s;
  logic               nib_c;
  logic               last;

  assign nib_a = a_q[NIB_W*int'(idx_q) +: NIB_W];
  assign nib_b = b_q[NIB_W*int'(idx_q) +: NIB_W];
  assign last  = (idx_q == LAST);

  full_adder_4bit_bh u_fa (
    .s    (nib_s),
    .cout (nib_c),
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid)  state_d = RUN;
      RUN:  if (last)      state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Operand capture and nibble-serial datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
          end
        end
        RUN: begin
          sum_q[NIB_W*int'(idx_q) +: NIB_W] <= nib_s;
          carry_q <= nib_c;
          if (last) cout_q <= nib_c;
          else      idx_q  <= idx_q + IDX_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl:
// directed cases plus randomized traffic vs a model.
module tb_nibble_serial_add_ctrl;

  localparam int W    = 16;
  localparam int NIBS = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_done_seen = 0;
  int acc_q[$];

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Model: an op is pending for NIBS edges after
  // acceptance, then the result waits for out_ready.
  logic         m_active;
  logic         m_done;
  int           m_cnt;
  logic [W:0]   m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_cnt    <= 0;
    end else if (m_active) begin
      if (m_cnt == 1) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end
      m_cnt <= m_cnt - 1;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (in_valid) begin
      m_exp    <= {1'b0, a} + {1'b0, b}
                + (W+1)'(cin);
      m_active <= 1'b1;
      m_cnt    <= NIBS;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready)
      acc_q.push_back(cyc);
  end

  // Compare DUT against the model every cycle
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready),
        64'(!(m_active || m_done)));
    chk("out_valid", 64'(out_valid), 64'(m_done));
    chk("busy", 64'(busy), 64'(m_active || m_done));
    if (m_done) begin
      n_done_seen++;
      chk("sum", 64'(sum), 64'(m_exp[W-1:0]));
      chk("cout", 64'(cout), 64'(m_exp[W]));
    end
    if (!rst_n) begin
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] xa,
                        input logic [W-1:0] xb,
                        input logic         xc,
                        input logic [W-1:0] es,
                        input logic         ec,
                        input int           hold);
    int n;
    logic [W-1:0] s0;
    logic         c0;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("wait_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a = xa;
    b = xb;
    cin = xc;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      a = 16'hAAAA;
      b = 16'hAAAA;
      cin = ~xc;
      in_valid = 1'($urandom);
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(n), 64'(NIBS));
    chk("op_sum", 64'(sum), 64'(es));
    chk("op_cout", 64'(cout), 64'(ec));
    s0 = sum;
    c0 = cout;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      step();
      chk("hold_sum", 64'(sum), 64'(s0));
      chk("hold_cout", 64'(cout), 64'(c0));
      chk("hold_ready", 64'(in_ready), 64'd0);
      chk("hold_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_ready", 64'(in_ready), 64'd1);
    chk("post_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_cout", 64'(cout), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    step();
    chk("release_ready", 64'(in_ready), 64'd1);

    run_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
    run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0);
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 5);

    // Abort in RUN
    in_valid = 1'b1;
    a = 16'h00FF;
    b = 16'h0001;
    cin = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("abort_no_valid", 64'(out_valid), 64'd0);
    end

    // Back-to-back with both handshakes held high
    acc_q.delete();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (8) step();
    out_ready = 1'b0;
    chk("b2b_count", 64'(acc_q.size() >= 4), 64'd1);
    for (int i = 1; i < acc_q.size(); i++)
      chk("b2b_gap", 64'(acc_q[i] - acc_q[i-1]),
          64'(NIBS + 2));

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      step();
      in_valid = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    chk("rand_done_seen", 64'(n_done_seen > 50), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
